// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and MUL/DIV
// front-end hold for a 5-stage MIPS pipeline, plus a saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mdu_op,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned CW       = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam int unsigned CNT_INIT = (MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0;
    localparam logic        MDU_HOLDS = (MDU_LATENCY > 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hold;
    logic          lu;

    // Load in EX feeding a register the ID instruction actually reads; $0 is exempt.
    always_comb begin
        lu = ex_mem_read && (ex_rt != 5'd0) &&
             ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MDU hold sequencing; ex_mdu_op is only sampled in RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        case (state)
            RUN: begin
                if (ex_mdu_op && MDU_HOLDS) begin
                    hold      = 1'b1;
                    state_nxt = MDU_WAIT;
                    cnt_nxt   = CW'(CNT_INIT);
                end
            end
            MDU_WAIT: begin
                if (cnt != '0) begin
                    hold    = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    // Priority: MDU hold, then branch squash, then load-use stall.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_busy      = 1'b0;
        if (!rst) begin
            if (hold) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                mdu_busy      = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
